// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: slice operation codes and
// sequencer FSM states.
package serial_alu_pkg;

   // Slice operation: the B-side operand fed to the 1-bit adder
   typedef enum logic [1:0] {
      OP_XFER = 2'd0,  // A + 0  + cin
      OP_ADD  = 2'd1,  // A + B  + cin
      OP_SUB  = 2'd2,  // A + ~B + cin
      OP_DEC  = 2'd3   // A + 1s + cin
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   // B-side bit presented to the full adder for a given operation
   function automatic logic slice_b_bit(input alu_op_e op, input logic b);
      logic r;
      case (op)
         OP_XFER: r = 1'b0;
         OP_ADD:  r = b;
         OP_SUB:  r = ~b;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/arithmetic_circuit.sv
// 1-bit arithmetic slice: full adder whose B input is selected by sel_i
// (0, B, ~B or 1). Purely combinational.
module arithmetic_circuit
   import serial_alu_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       cin_i,
   input  logic [1:0] sel_i,
   output logic       d_o,
   output logic       cout_o
);

   logic b_sel;

   // Operand select followed by a plain full adder
   always_comb begin
      b_sel  = slice_b_bit(alu_op_e'(sel_i), b_i);
      d_o    = a_i ^ b_sel ^ cin_i;
      cout_o = (a_i & b_sel) | (a_i & cin_i) | (b_sel & cin_i);
   end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial WIDTH-bit ALU controller around arithmetic_circuit.
// Operands stream LSB first, one bit pair per cycle; the slice carry is
// registered back into carry-in. The result and final carry are published on
// the RUN->DONE edge and held until the next operation completes.
// Handshake: ready_o is high in IDLE and DONE; start_i is accepted on a rising
// edge where ready_o=1 and start_i=1; done_o is high for the single DONE cycle.
// Optional feature: define SERIAL_ALU_FLAGS_EN to add zero_o / ovf_o.
module serial_alu_sequencer
   import serial_alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
)(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o
`ifdef SERIAL_ALU_FLAGS_EN
   ,
   output logic             zero_o,
   output logic             ovf_o
`endif
);

   seq_state_e       state_q, state_d;
   alu_op_e          op_q, op_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             slice_d;
   logic             slice_cout;
   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] res_shifted;

   arithmetic_circuit u_slice (
      .a_i    (a_sh_q[0]),
      .b_i    (b_sh_q[0]),
      .cin_i  (carry_q),
      .sel_i  (op_q),
      .d_o    (slice_d),
      .cout_o (slice_cout)
   );

   // Handshake decode and the result shift with the new sum bit entering at the MSB
   always_comb begin
      ready_o     = (state_q == ST_IDLE) || (state_q == ST_DONE);
      busy_o      = (state_q == ST_RUN);
      done_o      = (state_q == ST_DONE);
      accept      = ready_o && start_i;
      last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
      res_shifted = (res_sh_q >> 1) | {slice_d, {(WIDTH-1){1'b0}}};
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      result_d = result_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = res_shifted;
            carry_d  = slice_cout;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_bit) begin
               state_d  = ST_DONE;
               result_d = res_shifted;
               cout_d   = slice_cout;
            end
         end
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               state_d = ST_RUN;
               op_d    = alu_op_e'(op_i);
               a_sh_d  = a_i;
               b_sh_d  = b_i;
               carry_d = cin_i;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_XFER;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign result_o = result_q;
   assign cout_o   = cout_q;

`ifdef SERIAL_ALU_FLAGS_EN
   logic zacc_q, zacc_d;
   logic zero_q, zero_d;
   logic ovf_q, ovf_d;

   // Zero is a sticky OR of the sum bits; overflow compares carry into and out of the MSB
   always_comb begin
      zacc_d = zacc_q;
      zero_d = zero_q;
      ovf_d  = ovf_q;
      if (state_q == ST_RUN) begin
         zacc_d = zacc_q | slice_d;
         if (last_bit) begin
            zero_d = ~(zacc_q | slice_d);
            ovf_d  = carry_q ^ slice_cout;
         end
      end else if (accept) begin
         zacc_d = 1'b0;
      end
   end

   // Flag registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         zacc_q <= 1'b0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         zacc_q <= zacc_d;
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign zero_o = zero_q;
   assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer (WIDTH=32). Expected results,
// carries, flags and done timing are queued at issue and checked on done_o.
// Define SERIAL_ALU_FLAGS_EN to also check zero_o / ovf_o.
module tb_serial_alu_sequencer;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         ovf;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         cout_o;
`ifdef SERIAL_ALU_FLAGS_EN
  logic         zero_o;
  logic         ovf_o;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cin_i    (cin_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .cout_o   (cout_o)
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    .zero_o   (zero_o),
    .ovf_o    (ovf_o)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];      // {cout, result}
  logic [1:0] flag_q[$];     // {zero, ovf}
  int         done_cyc_q[$]; // cycle at which done_o is expected
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding operation
  always @(negedge clk) begin
    if (rst_ni === 1'b1 && done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done_o=1 required=no_done (cycle %0d)", cyc);
      end else begin
        logic [W:0] e;
        logic [1:0] f;
        int         c;
        e = exp_q.pop_front();
        f = flag_q.pop_front();
        c = done_cyc_q.pop_front();
        check("result", 64'(result_o), 64'(e[W-1:0]));
        check("cout", 64'(cout_o), 64'(e[W]));
        check("done_cycle", 64'(cyc), 64'(c));
`ifdef SERIAL_ALU_FLAGS_EN
        check("zero_flag", 64'(zero_o), 64'(f[1]));
        check("ovf_flag", 64'(ovf_o), 64'(f[0]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output logic ok);
    int n;
    n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (ready_o === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=ready_o=%b required=1", ready_o);
    end
  endtask

  task automatic issue(input vec_t v);
    logic ok;
    wait_ready(ok);
    if (!ok) return;
    op_i    = v.op;
    a_i     = v.a;
    b_i     = v.b;
    cin_i   = v.cin;
    start_i = 1'b1;
    exp_q.push_back({v.cout, v.res});
    flag_q.push_back({v.zero, v.ovf});
    done_cyc_q.push_back(cyc + 1 + W);
    @(negedge clk);
    start_i = 1'b0;
    // Operand inputs wander during RUN; they must not matter
    a_i   = $urandom;
    b_i   = $urandom;
    op_i  = 2'($urandom_range(0, 3));
    cin_i = 1'($urandom_range(0, 1));
    check("busy_in_run", 64'(busy_o), 64'd1);
    check("ready_in_run", 64'(ready_o), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_result"}, 64'(result_o), 64'd0);
    check({tag, "_cout"}, 64'(cout_o), 64'd0);
`ifdef SERIAL_ALU_FLAGS_EN
    check({tag, "_zero"}, 64'(zero_o), 64'd0);
    check({tag, "_ovf"}, 64'(ovf_o), 64'd0);
`endif
  endtask

  //                 op     a             b             cin   result        cout  zero  ovf
  vec_t v_add   = '{2'b01, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
  vec_t v_sub1  = '{2'b10, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
  vec_t v_sub2  = '{2'b10, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
  vec_t v_dec   = '{2'b11, 32'h0000_0000, 32'h1234_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
  vec_t v_xfer  = '{2'b00, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
  vec_t v_abort = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
  vec_t v_ign   = '{2'b01, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
  vec_t v_ovf   = '{2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
  vec_t v_zero  = '{2'b10, 32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
  vec_t v_neg   = '{2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
  vec_t v_wrap  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

  // ---------------- main sequence ----------------
  initial begin
    logic ok;
    int   n;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    op_i    = 2'b00;
    a_i     = '0;
    b_i     = '0;
    cin_i   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_init");
    rst_ni = 1'b1;

    issue(v_add);
    issue(v_sub1);
    issue(v_sub2);
    issue(v_dec);

    // Abort: reset lands around bit 10 of a RUN; no done_o may follow
    wait_ready(ok);
    if (ok) begin
      op_i    = v_abort.op;
      a_i     = v_abort.a;
      b_i     = v_abort.b;
      cin_i   = v_abort.cin;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_ni = 1'b0;
      #1 check_reset_outputs("reset_async");
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_held");
      rst_ni = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_stays_idle", 64'(ready_o), 64'd1);
    end

    issue(v_xfer);

    // Start pulsed at RUN bit 5 with different operands must be ignored
    issue(v_ign);
    repeat (4) @(negedge clk);
    op_i    = 2'b00;
    a_i     = 32'hDEAD_BEEF;
    b_i     = 32'h0;
    cin_i   = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;

    // Back-to-back issues: each accepted in DONE, spaced W+1 cycles
    issue(v_ovf);
    issue(v_zero);
    issue(v_neg);
    issue(v_wrap);

    // Drain outstanding operations
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("final_idle", 64'(ready_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
